// File: rtl/network_bf_in_pipe.sv
// network_bf_in_pipe: two-stage select/data crossbar feeding butterfly inputs, with a saturating lane-conflict counter.
module network_bf_in_pipe #(
  parameter int DATA_W = 14,
  parameter int LANES  = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_sel_valid,
  input  logic                     i_byp,
  input  logic [LANES*SEL_W-1:0]   i_sel,
  input  logic [LANES*DATA_W-1:0]  i_q,
  input  logic                     i_clr,
  output logic [LANES*DATA_W-1:0]  o_d,
  output logic                     o_d_valid,
  output logic                     o_conflict,
  output logic [CNT_W-1:0]         o_conflict_cnt
);
  logic [LANES*SEL_W-1:0]  r_sel;
  logic                    r_byp;
  logic                    r_sv;
  logic [LANES*DATA_W-1:0] r_d;
  logic                    r_dv;
  logic                    r_conflict;
  logic [CNT_W-1:0]        r_cnt;
  logic [LANES*DATA_W-1:0] w_route;
  logic [LANES*DATA_W-1:0] w_next;
  logic                    w_dup;
  always_comb begin
    w_route = '0;
    w_dup   = 1'b0;
    // ascending lane order lets the highest-numbered lane overwrite earlier ones on a collision
    for (int i = 0; i < LANES; i++)
      w_route[int'(r_sel[i*SEL_W +: SEL_W])*DATA_W +: DATA_W] = i_q[i*DATA_W +: DATA_W];
    for (int i = 0; i < LANES; i++)
      for (int j = i + 1; j < LANES; j++)
        w_dup = w_dup | (r_sel[i*SEL_W +: SEL_W] == r_sel[j*SEL_W +: SEL_W]);
  end
  assign w_next = r_byp ? i_q : w_route;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel      <= '0;
      r_byp      <= 1'b0;
      r_sv       <= 1'b0;
      r_d        <= '0;
      r_dv       <= 1'b0;
      r_conflict <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (i_en) begin
        r_sel      <= i_sel;
        r_byp      <= i_byp;
        r_sv       <= i_sel_valid;
        r_dv       <= r_sv;
        r_conflict <= r_sv & ~r_byp & w_dup;
        if (r_sv) r_d <= w_next;
      end
      if (i_clr) r_cnt <= '0;
      else if (i_en && r_dv && r_conflict && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_d            = r_d;
  assign o_d_valid      = r_dv;
  assign o_conflict     = r_conflict;
  assign o_conflict_cnt = r_cnt;
endmodule

// File: tb/tb_network_bf_in_pipe.sv
// tb_network_bf_in_pipe: random and directed stimulus checked against a behavioural crossbar model.
module tb_network_bf_in_pipe;
  localparam int DW   = 14;
  localparam int L    = 8;
  localparam int SW   = 3;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int VW   = L * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0, sv = 1'b0, byp = 1'b0, clr = 1'b0;
  logic [L*SW-1:0] sel = '0;
  logic [VW-1:0]   q = '0;
  logic [VW-1:0]   d;
  logic            dv, conf;
  logic [CW-1:0]   cnt;
  int vectors = 0, miscompares = 0;
  bit chk_on = 1'b0;

  network_bf_in_pipe #(.DATA_W(DW), .LANES(L), .SEL_W(SW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sel_valid(sv), .i_byp(byp),
    .i_sel(sel), .i_q(q), .i_clr(clr), .o_d(d), .o_d_valid(dv),
    .o_conflict(conf), .o_conflict_cnt(cnt));

  always #5 clk = ~clk;

  // reference routing: for each output, scan lanes from the top and take the first match
  function automatic logic [VW-1:0] ref_route(input logic [L*SW-1:0] s, input logic [VW-1:0] qq, input logic b);
    logic [VW-1:0] r;
    r = '0;
    for (int k = 0; k < L; k++) begin
      if (b) r[k*DW +: DW] = qq[k*DW +: DW];
      else
        for (int i = L - 1; i >= 0; i--)
          if (int'(s[i*SW +: SW]) == k) begin
            r[k*DW +: DW] = qq[i*DW +: DW];
            break;
          end
    end
    return r;
  endfunction

  function automatic bit ref_dup(input logic [L*SW-1:0] s);
    int hist[L];
    for (int k = 0; k < L; k++) hist[k] = 0;
    for (int i = 0; i < L; i++) hist[int'(s[i*SW +: SW])]++;
    for (int k = 0; k < L; k++) if (hist[k] > 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [L*SW-1:0] pack_sel(input int a[L]);
    logic [L*SW-1:0] r;
    for (int i = 0; i < L; i++) r[i*SW +: SW] = SW'(a[i]);
    return r;
  endfunction

  function automatic logic [VW-1:0] pack_q(input int a[L]);
    logic [VW-1:0] r;
    for (int i = 0; i < L; i++) r[i*DW +: DW] = DW'(a[i]);
    return r;
  endfunction

  function automatic logic [VW-1:0] q_seq(input int base);
    logic [VW-1:0] r;
    for (int i = 0; i < L; i++) r[i*DW +: DW] = DW'(base + i);
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_q();
    logic [VW-1:0] r;
    for (int i = 0; i < L; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  function automatic logic [L*SW-1:0] rand_sel();
    int a[L];
    int j, t;
    for (int i = 0; i < L; i++) a[i] = i;
    if ($urandom_range(0, 2) == 0) begin
      for (int i = L - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = a[i]; a[i] = a[j]; a[j] = t;
      end
    end else
      for (int i = 0; i < L; i++) a[i] = $urandom_range(0, L - 1);
    return pack_sel(a);
  endfunction

  // cycle model: S1 holds the accepted select word, S2 holds the routed word
  logic [L*SW-1:0] m_sel;
  logic            m_byp, m_sv, m_dv, m_conf;
  logic [VW-1:0]   m_d;
  int              m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sel <= '0; m_byp <= 1'b0; m_sv <= 1'b0; m_dv <= 1'b0;
      m_conf <= 1'b0; m_d <= '0; m_cnt <= 0;
    end else begin
      if (clr) m_cnt <= 0;
      else if (en && m_dv && m_conf) m_cnt <= (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      if (en) begin
        m_sel  <= sel;
        m_byp  <= byp;
        m_sv   <= sv;
        m_dv   <= m_sv;
        m_conf <= m_sv && !m_byp && ref_dup(m_sel);
        if (m_sv) m_d <= ref_route(m_sel, q, m_byp);
      end
    end
  end

  task automatic cmp(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("model_d", d, m_d);
      cmp("model_d_valid", VW'(dv), VW'(m_dv));
      cmp("model_conflict", VW'(conf), VW'(m_conf));
      cmp("model_cnt", VW'(cnt), VW'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int a[L];
    int e[L];
    int exp_cnt[6];
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    for (int n = 0; n < 4; n++) begin
      sel = rand_sel(); q = rand_q(); en = 1'($urandom); sv = 1'($urandom);
      byp = 1'($urandom); clr = 1'($urandom);
      tick();
      cmp("rst_d", d, '0);
      cmp("rst_flags", VW'({dv, conf, cnt}), '0);
    end
    rst_n = 1'b1; en = 1'b1; sv = 1'b0; byp = 1'b0; clr = 1'b0;
    tick(); tick();

    a = '{7, 6, 5, 4, 3, 2, 1, 0};
    sel = pack_sel(a); sv = 1'b1;
    tick();
    sv = 1'b0; q = q_seq(10);
    tick();
    e = '{17, 16, 15, 14, 13, 12, 11, 10};
    cmp("perm_d", d, pack_q(e));
    cmp("perm_valid", VW'(dv), VW'(1'b1));
    cmp("perm_conflict", VW'(conf), VW'(1'b0));

    clr = 1'b1; tick(); clr = 1'b0;
    a = '{3, 0, 1, 2, 4, 3, 5, 7};
    sel = pack_sel(a); sv = 1'b1;
    tick();
    sv = 1'b0; q = q_seq(1);
    tick();
    e = '{2, 3, 4, 6, 5, 7, 0, 8};
    cmp("coll_d", d, pack_q(e));
    cmp("coll_conflict", VW'(conf), VW'(1'b1));
    cmp("coll_cnt_before", VW'(cnt), VW'(0));
    tick();
    cmp("coll_cnt_after", VW'(cnt), VW'(1));

    byp = 1'b1; sv = 1'b1;
    tick();
    byp = 1'b0; sv = 1'b0; q = q_seq(1);
    tick();
    cmp("byp_d", d, q_seq(1));
    cmp("byp_conflict", VW'(conf), VW'(1'b0));
    tick();
    cmp("byp_cnt", VW'(cnt), VW'(1));

    for (int i = 0; i < L; i++) a[i] = i;
    sel = pack_sel(a); sv = 1'b1;
    tick();
    q = q_seq(100);
    tick();
    cmp("stall_w1", d, q_seq(100));
    en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      q = rand_q(); sel = rand_sel(); sv = 1'($urandom);
      tick();
      cmp("stall_hold_d", d, q_seq(100));
      cmp("stall_hold_valid", VW'(dv), VW'(1'b1));
    end
    en = 1'b1; sel = pack_sel(a); sv = 1'b1; q = q_seq(200);
    tick();
    cmp("stall_w2", d, q_seq(200));
    q = q_seq(300);
    tick();
    cmp("stall_w3", d, q_seq(300));
    sv = 1'b0; q = q_seq(400);
    tick();
    cmp("stall_w4", d, q_seq(400));
    tick();
    cmp("stall_drain_valid", VW'(dv), VW'(1'b0));

    clr = 1'b1; tick(); clr = 1'b0;
    a = '{3, 0, 1, 2, 4, 3, 5, 7};
    sel = pack_sel(a); sv = 1'b1;
    exp_cnt = '{0, 0, 1, 2, 3, 3};
    for (int n = 0; n < 6; n++) begin
      q = rand_q();
      tick();
      cmp("sat_cnt", VW'(cnt), VW'(exp_cnt[n]));
    end
    sv = 1'b0;
    tick();
    cmp("sat_hold", VW'(cnt), VW'(3));
    cmp("sat_w6_conflict", VW'(conf), VW'(1'b1));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cmp("sat_clr", VW'(cnt), VW'(0));

    sel = rand_sel(); sv = 1'b1;
    tick();
    rst_n = 1'b0;
    #1 cmp("midrst_valid", VW'(dv), VW'(1'b0));
    tick();
    rst_n = 1'b1; sv = 1'b0;
    tick(); tick();
    cmp("midrst_no_valid", VW'(dv), VW'(1'b0));

    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      en  = ($urandom_range(0, 9) < 8);
      sv  = ($urandom_range(0, 9) < 7);
      byp = ($urandom_range(0, 9) < 2);
      clr = ($urandom_range(0, 39) == 0);
      sel = rand_sel();
      q   = rand_q();
      tick();
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/network_bf_in_pipe.md
NETWORK_BF_IN_PIPE -- requirements
Module: network_bf_in_pipe

Interface
REQ-001 Parameter DATA_W, default 14, coefficient width in bits.
REQ-002 Parameter LANES, default 8, number of input and output lanes; power of two, minimum 2.
REQ-003 Parameter SEL_W, default 3, select width per lane; SHALL equal log2(LANES).
REQ-004 Parameter CNT_W, default 8, width of the conflict counter.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  global advance enable; when 0, every register holds.
REQ-008 sel_valid  input  1  marks sel and byp as valid in this cycle.
REQ-009 byp  input  1  identity-routing request, qualified by sel_valid.
REQ-010 sel  input  LANES*SEL_W  destination index for each input lane; lane i occupies bits [i*SEL_W +: SEL_W].
REQ-011 q  input  LANES*DATA_W  input lane data; lane i occupies bits [i*DATA_W +: DATA_W].
REQ-012 clr  input  1  synchronous clear of conflict_cnt.
REQ-013 d  output  LANES*DATA_W  routed data; output index k = 2m is butterfly m input u, and k = 2m+1 is butterfly m input v.
REQ-014 d_valid  output  1  d holds a routed word.
REQ-015 conflict  output  1  the word on d had two or more lanes that selected the same destination.
REQ-016 conflict_cnt  output  CNT_W  saturating count of conflicted words.

Function
REQ-017 Stage S1 SHALL register sel, byp and sel_valid into sel_r, byp_r and sv_r on each edge where en=1.
- Consequence: sel leads its data by one cycle, matching memory read latency.
REQ-018 Stage S2 SHALL register d, d_valid and conflict from q and the S1 registers on each edge where en=1.
REQ-019 Total latency SHALL be 2 enabled edges from sel to d, and 1 enabled edge from q to d.
REQ-020 d_valid SHALL load sv_r on each enabled edge.
REQ-021 d SHALL update only on edges where en=1 and sv_r=1; otherwise d SHALL hold its value.
REQ-022 Routing with byp_r=0 SHALL drive each output k with q lane i whenever sel_r lane i equals k.
REQ-023 An output k selected by no lane SHALL be 0.
REQ-024 When several lanes select the same output k, the highest-numbered lane SHALL win.
REQ-025 Routing with byp_r=1 SHALL drive output k with q lane k, ignoring sel_r.
REQ-026 The conflict register SHALL load 1 when sv_r=1, byp_r=0 and any two lanes of sel_r are equal; otherwise it SHALL load 0 on enabled edges.
REQ-027 conflict_cnt SHALL increment by 1 on each clock edge where the conflict register is 1, en=1 and d_valid=1.
REQ-028 conflict_cnt SHALL saturate at 2^CNT_W-1.
REQ-029 clr=1 SHALL zero conflict_cnt on the next edge, independent of en.
REQ-030 When clr=1 and an increment fall on the same edge, clr SHALL win.
REQ-031 The block SHALL accept a new sel every enabled cycle, giving full throughput with no bubbles.
REQ-032 Pipeline stages SHALL stall together: en=0 freezes both S1 and S2.
REQ-033 No state machine is required beyond the two pipeline stages and the counter.

Reset
REQ-034 While rst_n=0, all registers SHALL clear asynchronously: sel_r=0, byp_r=0, sv_r=0, d=0, d_valid=0, conflict=0, conflict_cnt=0.
REQ-035 Deassertion of rst_n SHALL be honoured on the next rising edge.
REQ-036 A reset asserted mid-stream SHALL discard all in-flight words; no d_valid SHALL follow for sel accepted before reset.

Verification
REQ-037 Bench SHALL cover reset values.
- Stimulus: rst_n=0 with random inputs.
- Response: d=0, d_valid=0, conflict=0, conflict_cnt=0, regardless of clk.
REQ-038 Bench SHALL cover permutation routing (LANES=8).
- Stimulus: sel lanes 0..7 = {7,6,5,4,3,2,1,0} at cycle t; q lanes = {10,11,...,17} at t+1.
- Response: d lanes = {17,16,...,10} with d_valid=1 and conflict=0 at t+2.
REQ-039 Bench SHALL cover a collision.
- Stimulus: sel lane 0 = 3 and lane 5 = 3, remaining lanes mapped to distinct values other than 3 and 6 with output 6 left unselected; q lane i = i+1.
- Response: d[3]=6, d[6]=0, conflict=1, and conflict_cnt increments to 1.
REQ-040 Bench SHALL cover bypass.
- Stimulus: byp=1 with the colliding sel of REQ-039.
- Response: d[k]=q lane k for all k, conflict=0, conflict_cnt unchanged.
REQ-041 Bench SHALL cover stall.
- Stimulus: back-to-back words with en=0 for 3 cycles mid-stream.
- Response: d, d_valid and conflict are frozen during the stall; no word is lost or duplicated; order is preserved.
REQ-042 Bench SHALL cover counter saturation and clear (CNT_W=2).
- Stimulus: 5 conflicted words, then clr=1 coinciding with a sixth conflicted word.
- Response: conflict_cnt reads 3 after the fourth word and stays 3; after the clr edge it reads 0.
